// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_pkg
// Description : Shared types and helpers for the synthesiser datapath:
//               ADSR state encoding and saturating add/sub helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_e;

    // Unsigned add clamped to an upper bound; a 33-bit sum cannot wrap.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] hi);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, hi}) begin
            return hi;
        end
        return sum[31:0];
    endfunction

    // Unsigned subtract clamped to a lower bound; never goes below zero.
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lo);
        logic [31:0] diff;
        diff = (a < b) ? 32'd0 : (a - b);
        if (diff < lo) begin
            return lo;
        end
        return diff;
    endfunction

endpackage
`default_nettype wire

// File: rtl/env_scale.sv
`default_nettype none
// ============================================================================
// Module      : env_scale
// Description : Combinational gain stage: signed sample times unsigned gain,
//               arithmetic right shift by the gain width (floor rounding).
// Revision    : 1.0 - initial release
// ============================================================================
module env_scale #(
    parameter int WIDTH_P     = 12,
    parameter int ENV_WIDTH_P = 8
) (
    input  logic signed [WIDTH_P-1:0]     i_data,
    input  logic        [ENV_WIDTH_P-1:0] i_env,
    output logic signed [WIDTH_P-1:0]     o_data
);

    // Full-precision product; the gain is zero-extended so it stays positive.
    logic signed [WIDTH_P+ENV_WIDTH_P:0] w_prod;
    logic signed [ENV_WIDTH_P:0]         w_env_s;

    assign w_env_s = $signed({1'b0, i_env});
    assign w_prod  = i_data * w_env_s;

    // Dropping the low ENV_WIDTH_P bits of a two's complement value is an
    // arithmetic shift (floor). The gain is below 2^ENV_WIDTH_P, so the
    // result always fits back into WIDTH_P bits.
    assign o_data = w_prod[WIDTH_P+ENV_WIDTH_P-1:ENV_WIDTH_P];

endmodule
`default_nettype wire

// File: rtl/adsr_envelope.sv
`default_nettype none
// ============================================================================
// Module      : adsr_envelope
// Description : ADSR amplitude envelope on a valid/ready sample stream.
//               Gain advances once per accepted sample; scaled sample is
//               presented through a 1-deep registered output.
//               Optional macro ADSR_EXP_RELEASE_EN selects an exponential
//               release (env -= max(env >> RELEASE_SHIFT_P, 1)) instead of
//               the linear RELEASE_STEP_P decrement.
// Revision    : 1.0 - initial release
// ============================================================================
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int WIDTH_P         = 12,
    parameter int ENV_WIDTH_P     = 8,
    parameter int ATTACK_STEP_P   = 32,
    parameter int DECAY_STEP_P    = 8,
    parameter int SUSTAIN_LEVEL_P = 128,
    parameter int RELEASE_STEP_P  = 16,
    parameter int RELEASE_SHIFT_P = 3
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      gate_i,
    input  logic                      valid_i,
    input  logic signed [WIDTH_P-1:0] data_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic signed [WIDTH_P-1:0] data_o,
    input  logic                      ready_i,
    output logic                      busy_o
);

    localparam logic [31:0] c_env_max = 32'((64'd1 << ENV_WIDTH_P) - 64'd1);
    localparam logic [31:0] c_sustain = 32'(SUSTAIN_LEVEL_P);
    localparam logic [31:0] c_attack  = 32'(ATTACK_STEP_P);
    localparam logic [31:0] c_decay   = 32'(DECAY_STEP_P);
`ifndef ADSR_EXP_RELEASE_EN
    localparam logic [31:0] c_release = 32'(RELEASE_STEP_P);
`endif

    adsr_state_e               r_state;
    adsr_state_e               w_state_nx;
    logic [ENV_WIDTH_P-1:0]    r_env;
    logic [ENV_WIDTH_P-1:0]    w_env_nx;
    logic [ENV_WIDTH_P-1:0]    w_env_att;
    logic [ENV_WIDTH_P-1:0]    w_env_dec;
    logic [ENV_WIDTH_P-1:0]    w_env_rel;
    logic                      r_valid;
    logic signed [WIDTH_P-1:0] r_data;
    logic signed [WIDTH_P-1:0] w_scaled;
    logic                      w_accept;

    assign ready_o  = ~r_valid | ready_i;
    assign w_accept = valid_i & ready_o;
    assign valid_o  = r_valid;
    assign data_o   = r_data;
    assign busy_o   = (r_state != IDLE);

    // Candidate gains for each moving phase, computed from the current gain.
    assign w_env_att = ENV_WIDTH_P'(sat_add(32'(r_env), c_attack, c_env_max));
    assign w_env_dec = ENV_WIDTH_P'(sat_sub(32'(r_env), c_decay, c_sustain));

`ifdef ADSR_EXP_RELEASE_EN
    logic [ENV_WIDTH_P-1:0] w_rel_dec;

    // Exponential release: decrement by a fraction of the gain, at least 1.
    always_comb begin
        w_rel_dec = r_env >> RELEASE_SHIFT_P;
        if ((w_rel_dec == '0) && (r_env != '0)) begin
            w_rel_dec = ENV_WIDTH_P'(1);
        end
        w_env_rel = r_env - w_rel_dec;
    end
`else
    assign w_env_rel = ENV_WIDTH_P'(sat_sub(32'(r_env), c_release, 32'd0));
`endif

    // Scale using the gain in force before this accept's update.
    env_scale #(
        .WIDTH_P     (WIDTH_P),
        .ENV_WIDTH_P (ENV_WIDTH_P)
    ) u_env_scale (
        .i_data (data_i),
        .i_env  (r_env),
        .o_data (w_scaled)
    );

    // Envelope state and gain register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_env   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_env   <= w_env_nx;
        end
    end

    // Next state / next gain; only an accepted sample moves the envelope and
    // a gate change takes priority over the step of that accept.
    always_comb begin
        w_state_nx = r_state;
        w_env_nx   = r_env;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    w_env_nx = '0;
                    if (gate_i) begin
                        w_state_nx = ATTACK;
                    end
                end
                ATTACK: begin
                    if (!gate_i) begin
                        w_state_nx = RELEASE;
                    end else begin
                        w_env_nx = w_env_att;
                        if (32'(w_env_att) == c_env_max) begin
                            w_state_nx = DECAY;
                        end
                    end
                end
                DECAY: begin
                    if (!gate_i) begin
                        w_state_nx = RELEASE;
                    end else begin
                        w_env_nx = w_env_dec;
                        if (32'(w_env_dec) == c_sustain) begin
                            w_state_nx = SUSTAIN;
                        end
                    end
                end
                SUSTAIN: begin
                    if (!gate_i) begin
                        w_state_nx = RELEASE;
                    end
                end
                RELEASE: begin
                    if (gate_i) begin
                        w_state_nx = ATTACK;
                    end else begin
                        w_env_nx = w_env_rel;
                        if (w_env_rel == '0) begin
                            w_state_nx = IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_env_nx   = '0;
                end
            endcase
        end
    end

    // 1-deep output register; data holds while the consumer stalls.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_scaled;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope.sv
`default_nettype none
// ============================================================================
// Module      : tb_adsr_envelope
// Description : Directed self-checking bench for adsr_envelope. A second
//               instance uses a full-scale sustain level for scaling checks.
//               Covers ADSR_EXP_RELEASE_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adsr_envelope;

    logic               clk   = 1'b0;
    logic               rst   = 1'b0;
    logic               gate  = 1'b0;
    logic               valid = 1'b0;
    logic               rdy   = 1'b1;
    logic signed [11:0] din   = '0;

    logic               ready_o, valid_o, busy_o;
    logic signed [11:0] data_o;
    logic               ready2_o, valid2_o, busy2_o;
    logic signed [11:0] data2_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adsr_envelope u_dut (
        .clk_i   (clk),
        .reset_i (rst),
        .gate_i  (gate),
        .valid_i (valid),
        .data_i  (din),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (rdy),
        .busy_o  (busy_o)
    );

    adsr_envelope #(.SUSTAIN_LEVEL_P(255)) u_dut_full (
        .clk_i   (clk),
        .reset_i (rst),
        .gate_i  (gate),
        .valid_i (valid),
        .data_i  (din),
        .ready_o (ready2_o),
        .valid_o (valid2_o),
        .data_o  (data2_o),
        .ready_i (rdy),
        .busy_o  (busy2_o)
    );

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // With data_i = -2048 the output is exactly -8 * gain.
    task automatic acc_env(input string tag, input int env);
        tick();
        check(tag, int'(data_o), -8 * env);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // 1 idle + 8 attack + 16 decay accepts land in SUSTAIN at 128.
    task automatic to_sustain;
        do_reset();
        gate  = 1'b1;
        valid = 1'b1;
        rdy   = 1'b1;
        din   = 12'sh800;
        repeat (25) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_valid", int'(valid_o), 0);
        check("rst_data",  int'(data_o),  0);
        check("rst_busy",  int'(busy_o),  0);
        check("rst_ready", int'(ready_o), 1);

        // Attack / decay timing
        gate  = 1'b1;
        valid = 1'b1;
        rdy   = 1'b1;
        din   = 12'sh800;
        tick();
        rst = 1'b0;
        acc_env("idle_acc", 0);
        check("busy_att", int'(busy_o), 1);
        for (int k = 0; k < 8; k++) begin
            acc_env($sformatf("att%0d", k), 32 * k);
            check("att_valid", int'(valid_o), 1);
        end
        for (int k = 0; k < 16; k++) begin
            acc_env($sformatf("dec%0d", k), 255 - 8 * k);
            check("dec_busy", int'(busy_o), 1);
        end
        acc_env("sus0", 128);
        acc_env("sus1", 128);

        // Scaling: main instance at 128, full-sustain instance at 255
        din = 12'sd1000;
        tick();
        check("scl_p128",  int'(data_o),  500);
        check("scl_p255",  int'(data2_o), 996);
        din = -12'sd1000;
        tick();
        check("scl_n128",  int'(data_o),  -500);
        check("scl_n255",  int'(data2_o), -997);
        din = 12'sh800;
        tick();
        check("scl_m128",  int'(data_o),  -1024);
        check("scl_m255",  int'(data2_o), -2040);

        // Asynchronous reset mid-cycle during SUSTAIN
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", int'(valid_o), 0);
        check("arst_data",  int'(data_o),  0);
        check("arst_busy",  int'(busy_o),  0);
        #2 rst = 1'b0;
        acc_env("rs_idle", 0);
        check("rs_busy", int'(busy_o), 1);
        acc_env("rs_att0", 0);
        acc_env("rs_att1", 32);

        // Backpressure
        do_reset();
        acc_env("bp_a0", 0);
        acc_env("bp_a1", 0);
        acc_env("bp_a2", 32);
        valid = 1'b0;
        tick();
        check("bp_bubble", int'(valid_o), 0);
        rdy   = 1'b0;
        valid = 1'b1;
        #1;
        check("bp_rdy_pre", int'(ready_o), 1);
        acc_env("bp_first", 64);
        din = 12'sd1000;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_ready", int'(ready_o), 0);
            check("bp_valid", int'(valid_o), 1);
            check("bp_hold",  int'(data_o),  -512);
        end
        rdy = 1'b1;
        din = 12'sh800;
        #1;
        check("bp_rdy_rel", int'(ready_o), 1);
        acc_env("bp_next", 96);
        acc_env("bp_next2", 128);

`ifdef ADSR_EXP_RELEASE_EN
        // Exponential release from 128
        to_sustain();
        gate = 1'b0;
        acc_env("xr_gate", 128);
        acc_env("xr0", 128);
        acc_env("xr1", 112);
        acc_env("xr2", 98);
        acc_env("xr3", 86);
        acc_env("xr4", 76);
        repeat (26) tick();
        check("xr_busy31", int'(busy_o), 1);
        acc_env("xr_last", 1);
        check("xr_idle", int'(busy_o), 0);
        acc_env("xr_zero", 0);
`else
        // Linear release from 128
        to_sustain();
        gate = 1'b0;
        acc_env("rel_gate", 128);
        for (int k = 0; k < 8; k++) begin
            acc_env($sformatf("rel%0d", k), 128 - 16 * k);
        end
        check("rel_idle", int'(busy_o), 0);
        acc_env("rel_zero", 0);
        check("rel_valid", int'(valid_o), 1);

        // Retrigger at 64
        to_sustain();
        gate = 1'b0;
        acc_env("rt_gate", 128);
        for (int k = 0; k < 4; k++) begin
            acc_env($sformatf("rt_rel%0d", k), 128 - 16 * k);
        end
        gate = 1'b1;
        acc_env("rt_hold", 64);
        acc_env("rt_a0", 64);
        acc_env("rt_a1", 96);
        acc_env("rt_a2", 128);
        check("rt_busy", int'(busy_o), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
